// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data RAM between the pipeline
// port (P) and the host port (H). Round-robin priority between the two, plus a
// host lock mode whose length is bounded by how long P has been kept waiting.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  p_req,
    input  logic                  p_we,
    input  logic [ADDR_WIDTH-1:0] p_addr,
    input  logic [DATA_WIDTH-1:0] p_wdata,
    output logic                  p_gnt,
    output logic                  p_rvalid,
    output logic                  p_err,
    output logic [DATA_WIDTH-1:0] p_rdata,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic                  h_lock,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic                  h_err,
    output logic [DATA_WIDTH-1:0] h_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            owner
);

    typedef enum logic [1:0] {
        RR_P   = 2'd0,
        RR_H   = 2'd1,
        LOCK_H = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

    // Saturating increment of the P-waiting counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= LOCK_LIM) ? LOCK_LIM : v + 8'd1;
    endfunction

    // Address lies inside the populated part of the RAM.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) < DEPTH);
    endfunction

    state_t      state, state_nxt;
    logic [7:0]  lock_cnt, lock_cnt_nxt, lock_cnt_inc;
    logic        relock_blk, relock_blk_nxt;

    // Grant stage: decision before reset gating, and address range checks.
    logic        p_gnt_p0, h_gnt_p0;
    logic        p_ok_p0, h_ok_p0;

    // Return stage: registered read owner tag and error pulses.
    logic        rd_vld_p1, rd_tag_p1;
    logic        p_err_p1, h_err_p1;

    assign p_ok_p0      = in_range(p_addr);
    assign h_ok_p0      = in_range(h_addr);
    assign lock_cnt_inc = p_req ? sat_inc(lock_cnt) : lock_cnt;

    // Grant decision and next-state logic for the arbitration FSM.
    always_comb begin
        state_nxt      = state;
        lock_cnt_nxt   = lock_cnt;
        relock_blk_nxt = relock_blk;
        p_gnt_p0       = 1'b0;
        h_gnt_p0       = 1'b0;
        // A forced unlock stays in effect until the host lets go of h_lock.
        if (!h_lock) begin
            relock_blk_nxt = 1'b0;
        end
        case (state)
            RR_P: begin
                if (p_req) begin
                    p_gnt_p0 = 1'b1;
                end else if (h_req) begin
                    h_gnt_p0 = 1'b1;
                end
            end
            RR_H: begin
                if (h_req) begin
                    h_gnt_p0 = 1'b1;
                end else if (p_req) begin
                    p_gnt_p0 = 1'b1;
                end
            end
            LOCK_H: begin
                h_gnt_p0 = h_req;
            end
            default: begin
                state_nxt = RR_P;
            end
        endcase
        if (state == RR_P || state == RR_H) begin
            if (p_gnt_p0) begin
                state_nxt = RR_H;
            end else if (h_gnt_p0) begin
                if (h_lock && !relock_blk) begin
                    state_nxt    = LOCK_H;
                    lock_cnt_nxt = 8'd0;
                end else begin
                    state_nxt = RR_P;
                end
            end
        end else if (state == LOCK_H) begin
            lock_cnt_nxt = lock_cnt_inc;
            if (lock_cnt_inc == LOCK_LIM) begin
                state_nxt      = RR_P;
                relock_blk_nxt = h_lock;
            end else if (!h_lock) begin
                state_nxt = RR_P;
            end
        end
    end

    // Arbitration state, lock counter and relock block.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RR_P;
            lock_cnt   <= 8'd0;
            relock_blk <= 1'b0;
        end else begin
            state      <= state_nxt;
            lock_cnt   <= lock_cnt_nxt;
            relock_blk <= relock_blk_nxt;
        end
    end

    assign p_gnt = p_gnt_p0 & reset_n;
    assign h_gnt = h_gnt_p0 & reset_n;
    assign owner = state;

    // RAM drive muxed from the granted port; idle bus is all zeros.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p_gnt) begin
            mem_en    = p_ok_p0;
            mem_we    = p_we;
            mem_addr  = p_addr;
            mem_wdata = p_wdata;
        end else if (h_gnt) begin
            mem_en    = h_ok_p0;
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end
    end

    // Grant -> return boundary: remember who owns the read data and who erred.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_p1 <= 1'b0;
            rd_tag_p1 <= 1'b0;
            p_err_p1  <= 1'b0;
            h_err_p1  <= 1'b0;
        end else begin
            rd_vld_p1 <= (p_gnt & ~p_we & p_ok_p0) | (h_gnt & ~h_we & h_ok_p0);
            rd_tag_p1 <= h_gnt;
            p_err_p1  <= p_gnt & ~p_ok_p0;
            h_err_p1  <= h_gnt & ~h_ok_p0;
        end
    end

    assign p_rvalid = rd_vld_p1 & ~rd_tag_p1;
    assign h_rvalid = rd_vld_p1 & rd_tag_p1;
    assign p_err    = p_err_p1;
    assign h_err    = h_err_p1;
    assign p_rdata  = p_rvalid ? mem_rdata : '0;
    assign h_rdata  = h_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic,
// checked against a rule-level reference model and a response scoreboard.
module tb_dmem_arbiter;
    localparam int AW       = 10;
    localparam int DW       = 32;
    localparam int DEPTH    = 1000;
    localparam int LOCK_MAX = 5;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          p_req = 1'b0, p_we = 1'b0;
    logic          h_req = 1'b0, h_we = 1'b0, h_lock = 1'b0;
    logic [AW-1:0] p_addr = '0, h_addr = '0;
    logic [DW-1:0] p_wdata = '0, h_wdata = '0;
    logic          p_gnt, p_rvalid, p_err, h_gnt, h_rvalid, h_err;
    logic [DW-1:0] p_rdata, h_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [1:0]    owner;

    always #5 clock = ~clock;

    dmem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_err(p_err), .p_rdata(p_rdata),
        .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_err(h_err), .h_rdata(h_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    // Synchronous RAM attached to the arbiter.
    logic [DW-1:0] ram    [1<<AW];
    logic [DW-1:0] shadow [1<<AW];

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        int            due;
        bit            err;
        logic [DW-1:0] data;
    } resp_t;

    resp_t pq[$];
    resp_t hq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: who has priority, whether H holds the lock, how long P waited,
    // and whether H must release h_lock before it may lock again.
    bit m_prio_h, m_locked, m_block;
    int m_wait;

    // DUT values sampled during the last tick.
    logic       s_pg, s_hg, s_men;
    logic [1:0] s_own;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prio_h = 1'b0;
        m_locked = 1'b0;
        m_block  = 1'b0;
        m_wait   = 0;
    endtask

    task automatic check_quiet(string tag);
        chk({tag, "_ctrl"}, 64'({p_gnt, h_gnt, mem_en, p_rvalid, h_rvalid, p_err, h_err, owner}), 64'(0));
        chk({tag, "_bus"}, 64'({mem_we, mem_addr, mem_wdata}), 64'(0));
        chk({tag, "_rdata"}, 64'({p_rdata, h_rdata}), 64'(0));
    endtask

    // Called at a falling edge with inputs already driven: checks this cycle's
    // grant and RAM drive, queues expected responses, advances the model.
    task automatic tick();
        bit            gp, gh, pin, hin, een, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [1:0]    eo;
        #1;
        pin = (int'(p_addr) < DEPTH);
        hin = (int'(h_addr) < DEPTH);
        eo  = m_locked ? 2'd2 : (m_prio_h ? 2'd1 : 2'd0);
        if (m_locked) begin
            gp = 1'b0; gh = h_req;
        end else if (p_req && h_req) begin
            gp = !m_prio_h; gh = m_prio_h;
        end else begin
            gp = p_req; gh = h_req;
        end
        een = 1'b0; ewe = 1'b0; ea = '0; ed = '0;
        if (gp) begin
            een = pin; ewe = p_we; ea = p_addr; ed = p_wdata;
        end else if (gh) begin
            een = hin; ewe = h_we; ea = h_addr; ed = h_wdata;
        end
        chk("owner", 64'(owner), 64'(eo));
        chk("p_gnt", 64'(p_gnt), 64'(gp));
        chk("h_gnt", 64'(h_gnt), 64'(gh));
        chk("mem_en", 64'(mem_en), 64'(een));
        chk("mem_bus", 64'({mem_we, mem_addr, mem_wdata}), 64'({ewe, ea, ed}));
        s_pg = p_gnt; s_hg = h_gnt; s_men = mem_en; s_own = owner;
        if (gp) begin
            if (!pin)       pq.push_back('{due: cyc + 1, err: 1'b1, data: '0});
            else if (!p_we) pq.push_back('{due: cyc + 1, err: 1'b0, data: shadow[p_addr]});
            else            shadow[p_addr] = p_wdata;
        end
        if (gh) begin
            if (!hin)       hq.push_back('{due: cyc + 1, err: 1'b1, data: '0});
            else if (!h_we) hq.push_back('{due: cyc + 1, err: 1'b0, data: shadow[h_addr]});
            else            shadow[h_addr] = h_wdata;
        end
        if (m_locked) begin
            if (p_req && m_wait < LOCK_MAX) m_wait++;
            if (m_wait == LOCK_MAX) begin
                m_locked = 1'b0; m_prio_h = 1'b0; m_block = h_lock;
            end else if (!h_lock) begin
                m_locked = 1'b0; m_prio_h = 1'b0;
            end
        end else if (gp) begin
            m_prio_h = 1'b1;
        end else if (gh) begin
            if (h_lock && !m_block) begin
                m_locked = 1'b1; m_wait = 0;
            end else begin
                m_prio_h = 1'b0;
            end
        end
        if (!h_lock) m_block = 1'b0;
        @(negedge clock);
        cyc++;
    endtask

    // Asserts reset (asynchronously), holds it across one rising edge, releases.
    task automatic assert_reset(string tag);
        reset_n = 1'b0;
        pq.delete();
        hq.delete();
        #1;
        check_quiet({tag, "_in_rst"});
        @(negedge clock);
        cyc++;
        check_quiet({tag, "_held"});
        reset_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return AW'($urandom_range(DEPTH, (1 << AW) - 1));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    // Response monitor: compares returned data/errors against the scoreboard.
    initial begin : monitor
        forever begin
            @(negedge clock);
            #2;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                chk("p_rvalid", 64'(p_rvalid), 64'(!pq[0].err));
                chk("p_err", 64'(p_err), 64'(pq[0].err));
                chk("p_rdata", 64'(p_rdata), 64'(pq[0].data));
                pq.delete(0);
            end else begin
                chk("p_idle", 64'({p_rvalid, p_err, p_rdata}), 64'(0));
            end
            if (hq.size() > 0 && hq[0].due == cyc) begin
                chk("h_rvalid", 64'(h_rvalid), 64'(!hq[0].err));
                chk("h_err", 64'(h_err), 64'(hq[0].err));
                chk("h_rdata", 64'(h_rdata), 64'(hq[0].data));
                hq.delete(0);
            end else begin
                chk("h_idle", 64'({h_rvalid, h_err, h_rdata}), 64'(0));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         np, nh, cnt;
        logic [5:0] pbits, hbits;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]    = DW'(i) * 32'h9E37_79B1;
            shadow[i] = ram[i];
        end
        ram[5]    = 32'hDEAD_BEEF;
        shadow[5] = 32'hDEAD_BEEF;
        model_reset();

        // Reset state
        repeat (2) @(negedge clock);
        cyc += 2;
        #1;
        check_quiet("reset");
        @(negedge clock);
        cyc++;
        reset_n = 1'b1;

        // P reads address 5
        p_req = 1'b1; p_we = 1'b0; p_addr = AW'(5);
        tick();
        chk("t1_p_gnt", 64'(s_pg), 64'(1));
        p_req = 1'b0;
        #3;
        chk("t1_p_rdata", 64'(p_rdata), 64'(32'hDEAD_BEEF));
        chk("t1_h_rvalid", 64'(h_rvalid), 64'(0));
        // Reset while read data is being returned drops it immediately
        assert_reset("t1_rst");

        // Both ports write continuously from RR_P
        np = 0; nh = 0; pbits = '0; hbits = '0;
        p_req = 1'b1; p_we = 1'b1; p_addr = AW'(100); p_wdata = $urandom;
        h_req = 1'b1; h_we = 1'b1; h_addr = AW'(200); h_wdata = $urandom;
        for (int i = 0; i < 6; i++) begin
            tick();
            pbits[5-i] = s_pg;
            hbits[5-i] = s_hg;
            if (s_pg) begin np++; p_addr = AW'(100 + np); p_wdata = $urandom; end
            if (s_hg) begin nh++; h_addr = AW'(200 + nh); h_wdata = $urandom; end
        end
        chk("t2_p_order", 64'(pbits), 64'(6'b101010));
        chk("t2_h_order", 64'(hbits), 64'(6'b010101));
        p_req = 1'b0; h_req = 1'b0;

        // H locks, four writes while P waits, then releases
        cnt = 0; pbits = '0;
        h_lock = 1'b1; h_req = 1'b1; h_we = 1'b1; h_addr = AW'(400); h_wdata = $urandom;
        tick();
        cnt += int'(s_hg);
        p_req = 1'b1; p_we = 1'b0; p_addr = AW'(42);
        for (int i = 0; i < 3; i++) begin
            if (s_hg) begin h_addr = h_addr + 1'b1; h_wdata = $urandom; end
            tick();
            cnt += int'(s_hg);
            pbits[i] = s_pg;
        end
        h_lock = 1'b0; h_req = 1'b0;
        tick();
        pbits[3] = s_pg;
        chk("t3_locked_owner", 64'(s_own), 64'(2));
        tick();
        chk("t3_owner_after", 64'(s_own), 64'(0));
        chk("t3_p_gnt_after", 64'(s_pg), 64'(1));
        chk("t3_h_grants", 64'(cnt), 64'(4));
        chk("t3_p_blocked", 64'(pbits[3:0]), 64'(0));
        p_req = 1'b0;

        // H holds the lock until P's wait bound forces it out
        cnt = 0;
        h_lock = 1'b1; h_req = 1'b1; h_we = 1'b1;
        p_req = 1'b1; p_we = 1'b1; p_wdata = $urandom;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (s_own == 2'd2) cnt++;
            if (i == 6) begin
                chk("t4_owner_exit", 64'(s_own), 64'(0));
                chk("t4_p_gnt_exit", 64'(s_pg), 64'(1));
            end
            if (s_pg) begin p_addr = p_addr + 1'b1; p_wdata = $urandom; end
            if (s_hg) begin h_addr = h_addr + 1'b1; h_wdata = $urandom; end
        end
        chk("t4_locked_cycles", 64'(cnt), 64'(LOCK_MAX));
        p_req = 1'b0; h_req = 1'b0; h_lock = 1'b0;

        // H reads an out-of-range address
        h_req = 1'b1; h_we = 1'b0; h_addr = AW'(DEPTH);
        tick();
        chk("t5_h_gnt", 64'(s_hg), 64'(1));
        chk("t5_mem_en", 64'(s_men), 64'(0));
        h_req = 1'b0;
        #3;
        chk("t5_h_err", 64'(h_err), 64'(1));
        chk("t5_h_rvalid", 64'(h_rvalid), 64'(0));
        tick();

        // P read granted, reset pulsed before the next edge
        p_req = 1'b1; p_we = 1'b0; p_addr = AW'(9);
        #1;
        chk("t6_p_gnt", 64'(p_gnt), 64'(1));
        #2;
        assert_reset("t6_rst");
        p_req = 1'b0;
        chk("t6_p_rvalid", 64'(p_rvalid), 64'(0));
        tick();
        check_quiet("t6_after");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!p_req || s_pg) begin
                p_req = ($urandom_range(0, 3) != 0); p_we = 1'($urandom_range(0, 1));
                p_addr = rand_addr(); p_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                p_req = 1'b0;
            end
            if (!h_req || s_hg) begin
                h_req = ($urandom_range(0, 2) != 0); h_we = 1'($urandom_range(0, 1));
                h_addr = rand_addr(); h_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                h_req = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) h_lock = ~h_lock;
            if ($urandom_range(0, 399) == 0) begin
                assert_reset("rand_rst");
                s_pg = 1'b0; s_hg = 1'b0;
            end else begin
                tick();
            end
        end

        // Drain outstanding responses
        p_req = 1'b0; h_req = 1'b0; h_lock = 1'b0;
        tick();
        tick();
        chk("drain_p", 64'(pq.size()), 64'(0));
        chk("drain_h", 64'(hq.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
